clk_mon: RTL
============

Name: clk_mon

Overview:
- Frequency/duty monitor for a gated clock such as the output of the team's clk_gen block.
- Samples the monitored clock as data in the reference clock domain and measures period and high time in reference-clock cycles.
- Flags when the monitored clock stops and when it restarts.
- Sits beside the clock generator as the checking end of its output, for on-chip self-test and bench observation.

Parameters:
- CNT_W, 16, width of period/high counters and outputs
- TIMEOUT, 64, reference cycles with no monitored edge before declaring clock stopped; must satisfy 4 <= TIMEOUT <= 2**CNT_W-1
- SYNC_STAGES, 2, synchronizer depth for mon_clk (min 2)

Ports:
- clk_in  input  1  reference clock, rising-edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- en  input  1  monitor enable (synchronous level)
- mon_clk  input  1  monitored clock, asynchronous to clk_in
- meas_valid  output  1  one-cycle pulse: period_out/high_out updated
- period_out  output  CNT_W  clk_in cycles between consecutive mon_clk rising edges
- high_out  output  CNT_W  clk_in cycles mon_clk was high within that period
- clk_active  output  1  level: monitored clock currently toggling
- stopped  output  1  one-cycle pulse on RUN->STOP transition

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; sync chain 0.
- Synchronizer: SYNC_STAGES flops, then one history flop s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
- Latency: mon_clk rise to meas_valid is SYNC_STAGES+2 clk_in edges.
- States:
  - IDLE: entered when en=0 (from any state, takes priority); counters cleared; clk_active=0. en=1 -> ARM.
  - ARM: waits for first rise; no measurement (interval unknown). rise -> RUN, period_cnt<=1, high_cnt<=1, clk_active<=1. idle_cnt reaching TIMEOUT -> STOP, no stopped pulse.
  - RUN: period_cnt increments every cycle, saturating at 2**CNT_W-1. high_cnt increments on cycles with s=1 and no rise; frozen after fall.
    - On rise: period_out<=period_cnt, high_out<=high_cnt, meas_valid<=1, then period_cnt<=1, high_cnt<=1.
  - STOP: clk_active=0; period_out/high_out hold last values. rise -> RUN as in ARM (counters restart, no meas_valid on this first rise). stopped pulses 1 cycle on entry from RUN only.
- idle_cnt: cleared on any rise or fall, else increments, saturating. Reaching TIMEOUT in RUN -> STOP that cycle.
- Simultaneous events:
  - en falling with rise: IDLE wins, no meas_valid.
  - A rise in the same cycle idle_cnt would hit TIMEOUT: rise wins, stays RUN.
- Outputs are registered. meas_valid and stopped are never high in the same cycle.
- en=0 holds period_out/high_out at last values. They are cleared only by reset.
- Async reset mid-measurement clears everything immediately. After release the block restarts in IDLE.
- Monitored clock must have high and low phases >= 2 clk_in cycles each; narrower pulses may be missed (not flagged).

Decomposition:
- Shared package clk_mon_pkg:
  - state encoding localparams IDLE=2'd0, ARM=2'd1, RUN=2'd2, STOP=2'd3
  - TIMEOUT/CNT_W defaults, reused by the bench
- One sub-module, sync_edge_det: SYNC_STAGES synchronizer, history flop, rise/fall outputs, async active-low reset. Also reusable for other asynchronous inputs.

Test Plan:
- Square wave: rst_n released, en=1, mon_clk period 10 clk_in cycles, 50% duty -> after the 2nd rise, meas_valid every 10 cycles with period_out=10, high_out=5; clk_active=1.
- Duty change: mon_clk high 3 / low 7 cycles -> period_out=10, high_out=3. Then high 8 / low 12 -> period_out=20, high_out=8 on the first full period after the change.
- Stop detection: mon_clk held low after running, TIMEOUT=64 -> stopped pulses once 64 cycles after the last fall; clk_active=0; period_out holds 10. Restart -> first rise gives no meas_valid, second rise gives meas_valid with correct period.
- Enable gating: mirror clk_gen pattern, en=1 for 100 cycles, 0 for 200, 1 for 200 with mon_clk running -> no meas_valid while en=0. After re-enable, the first meas_valid comes on the 2nd rise. Outputs hold across the disabled window.
- Reset mid-operation: assert rst_n low between two rises while in RUN -> all outputs 0 asynchronously, before the next clk_in edge. After release plus en=1, measurement resumes from ARM with correct values.
- Boundary: mon_clk never toggles from reset with en=1 -> STOP after 64 cycles, stopped never pulses, clk_active stays 0.

Source files
------------

// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_mon_pkg
//  Description : Shared state encoding and default sizing for the clock monitor.
//  Revision    : 1.0
// ============================================================================
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int c_cnt_w_def       = 16;
    localparam int c_timeout_def     = 64;
    localparam int c_sync_stages_def = 2;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer with registered rise/fall strobes and
//                a level output aligned to those strobes.
//  Revision    : 1.0
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // The history flop doubles as the level output: it is one cycle behind s,
    // exactly like the registered strobes, so level and rise/fall line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_s_d  <= w_s;
            r_rise <= w_s & ~r_s_d;
            r_fall <= ~w_s & r_s_d;
        end
    end

    assign o_level = r_s_d;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/clk_mon.sv
`default_nettype none
// ============================================================================
//  Module      : clk_mon
//  Description : Period / high-time monitor for an asynchronous clock, with
//                stop and restart detection, measured in clk_in cycles.
//  Revision    : 1.0
// ============================================================================
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w_def,
    parameter int TIMEOUT     = c_timeout_def,
    parameter int SYNC_STAGES = c_sync_stages_def
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mon_clk,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             clk_active,
    output logic             stopped
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    logic w_level, w_rise, w_fall, w_edge, w_timeout;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_period_cnt, w_period_cnt_nxt;
    logic [CNT_W-1:0] r_high_cnt, w_high_cnt_nxt;
    logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt, w_idle_inc;
    logic [CNT_W-1:0] r_period_out, w_period_out_nxt;
    logic [CNT_W-1:0] r_high_out, w_high_out_nxt;
    logic             r_meas_valid, w_meas_valid_nxt;
    logic             r_clk_active, w_clk_active_nxt;
    logic             r_stopped, w_stopped_nxt;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk_in),
        .rst_n   (rst_n),
        .i_d     (mon_clk),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge     = w_rise | w_fall;
    assign w_idle_inc = (r_idle_cnt == c_cnt_max) ? r_idle_cnt : r_idle_cnt + 1'b1;
    // Timeout fires on the cycle the idle count would reach TIMEOUT; an edge wins.
    assign w_timeout  = !w_edge && (w_idle_inc >= c_timeout);

    always_comb begin
        w_state_nxt      = r_state;
        w_period_cnt_nxt = r_period_cnt;
        w_high_cnt_nxt   = r_high_cnt;
        w_idle_cnt_nxt   = w_edge ? '0 : w_idle_inc;
        w_period_out_nxt = r_period_out;
        w_high_out_nxt   = r_high_out;
        w_meas_valid_nxt = 1'b0;
        w_clk_active_nxt = r_clk_active;
        w_stopped_nxt    = 1'b0;

        if (!en) begin
            w_state_nxt      = IDLE;
            w_period_cnt_nxt = '0;
            w_high_cnt_nxt   = '0;
            w_idle_cnt_nxt   = '0;
            w_clk_active_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt    = ARM;
                    w_idle_cnt_nxt = '0;
                end
                ARM, STOP: begin
                    // First rise only starts the interval; nothing to report yet.
                    if (w_rise) begin
                        w_state_nxt      = RUN;
                        w_period_cnt_nxt = CNT_W'(1);
                        w_high_cnt_nxt   = CNT_W'(1);
                        w_clk_active_nxt = 1'b1;
                    end else if (r_state == ARM && w_timeout) begin
                        w_state_nxt = STOP;
                    end
                end
                RUN: begin
                    if (r_period_cnt != c_cnt_max)
                        w_period_cnt_nxt = r_period_cnt + 1'b1;
                    if (w_level && !w_rise && r_high_cnt != c_cnt_max)
                        w_high_cnt_nxt = r_high_cnt + 1'b1;
                    if (w_rise) begin
                        w_period_out_nxt = r_period_cnt;
                        w_high_out_nxt   = r_high_cnt;
                        w_meas_valid_nxt = 1'b1;
                        w_period_cnt_nxt = CNT_W'(1);
                        w_high_cnt_nxt   = CNT_W'(1);
                    end else if (w_timeout) begin
                        w_state_nxt      = STOP;
                        w_stopped_nxt    = 1'b1;
                        w_clk_active_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_period_out <= '0;
            r_high_out   <= '0;
            r_meas_valid <= 1'b0;
            r_clk_active <= 1'b0;
            r_stopped    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_high_cnt   <= w_high_cnt_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_period_out <= w_period_out_nxt;
            r_high_out   <= w_high_out_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_clk_active <= w_clk_active_nxt;
            r_stopped    <= w_stopped_nxt;
        end
    end

    assign meas_valid = r_meas_valid;
    assign period_out = r_period_out;
    assign high_out   = r_high_out;
    assign clk_active = r_clk_active;
    assign stopped    = r_stopped;

endmodule
`default_nettype wire
